// File: rtl/cache_axi_pkg.sv
// Shared types and AXI encodings for the ICache refill path.
package cache_axi_pkg;

  typedef enum logic [1:0] {IDLE, AR, RDATA, RESP} refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Clear the byte-offset bits so the burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned line_bytes);
    logic [31:0] mask;
    mask = line_bytes[31:0] - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Line assembly buffer: LINE_WORDS x 32 words filled in beat order, flat line output.
module refill_line_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  output logic                     full,
  output logic [LINE_WORDS*32-1:0] line_data
);

  localparam int CNT_W = $clog2(LINE_WORDS) + 1;

  logic [LINE_WORDS-1:0][31:0] words_q, words_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  assign full      = (cnt_q == CNT_W'(LINE_WORDS));
  assign line_data = words_q;

  // Once full, extra beats are dropped: no wrap and no overwrite.
  always_comb begin
    words_d = words_q;
    cnt_d   = cnt_q;
    if (clr) begin
      words_d = '0;
      cnt_d   = '0;
    end else if (wr_en && !full) begin
      for (int i = 0; i < LINE_WORDS; i++)
        if (cnt_q == CNT_W'(i)) words_d[i] = wr_data;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      cnt_q   <= '0;
    end else begin
      words_q <= words_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/icache_axi_refill_bridge.sv
// ICache line refill -> single AXI4 INCR read burst, line returned in one cycle.
// Optional perf counters when ICACHE_REFILL_PERF_EN is defined.
module icache_axi_refill_bridge
  import cache_axi_pkg::*;
#(
  parameter int                 LINE_WORDS = 4,
  parameter int                 ID_W       = 4,
  parameter logic [ID_W-1:0]    AXI_ID     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_req,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic                     ret_last,
  output logic [LINE_WORDS*32-1:0] ret_data,
  output logic                     ret_err,
  output logic [ID_W-1:0]          arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]              perf_refills,
  output logic [31:0]              perf_wait_cycles
`endif
);

  refill_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic          buf_clr, buf_wr, buf_full, beat_acc;

  assign beat_acc = (state_q == RDATA) && rvalid && (rid == AXI_ID);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    buf_clr = 1'b0;
    buf_wr  = 1'b0;
    case (state_q)
      IDLE: if (rd_req) begin
        addr_d  = line_align(rd_addr, LINE_WORDS * 4);
        err_d   = 1'b0;
        buf_clr = 1'b1;
        state_d = AR;
      end
      AR: if (arready) state_d = RDATA;
      RDATA: if (beat_acc) begin
        buf_wr = 1'b1;
        if (!buf_full) err_d = err_q | (rresp != AXI_RESP_OKAY);
        if (rlast) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  refill_line_buffer #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .wr_en     (buf_wr),
    .wr_data   (rdata),
    .full      (buf_full),
    .line_data (ret_data)
  );

  assign rd_rdy    = (state_q == IDLE);
  assign arvalid   = (state_q == AR);
  assign rready    = (state_q == RDATA);
  assign ret_valid = (state_q == RESP);
  assign ret_last  = ret_valid;
  assign ret_err   = ret_valid & err_q;

  // AR payload comes only from the latched address and constants, so it is stable while stalled.
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] perf_refills_q, perf_refills_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_refills_d = perf_refills_q + ((state_q == RESP) ? 32'd1 : 32'd0);
    perf_wait_d    = perf_wait_q + (((state_q == AR) || (state_q == RDATA)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_refills_q <= '0;
      perf_wait_q    <= '0;
    end else begin
      perf_refills_q <= perf_refills_d;
      perf_wait_q    <= perf_wait_d;
    end
  end

  assign perf_refills     = perf_refills_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_icache_axi_refill_bridge.sv
// Randomized bench for icache_axi_refill_bridge with an in-bench AXI responder and line model.
module tb_icache_axi_refill_bridge;

  localparam int              LW     = 4;
  localparam int              ID_W   = 4;
  localparam logic [ID_W-1:0] AXI_ID = 4'd5;
  localparam int              DW     = LW * 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_req = 1'b0;
  logic [31:0]     rd_addr = '0;
  logic            rd_rdy, ret_valid, ret_last, ret_err;
  logic [DW-1:0]   ret_data;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst, arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid, rready;
  logic            arready = 1'b0;
  logic [ID_W-1:0] rid = '0;
  logic [31:0]     rdata = '0;
  logic [1:0]      rresp = '0;
  logic            rlast = 1'b0;
  logic            rvalid = 1'b0;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]     perf_refills, perf_wait_cycles;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_refills = 0;
  int exp_wait = 0;

  always #5 clk = ~clk;

  icache_axi_refill_bridge #(.LINE_WORDS(LW), .ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .ret_err(ret_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef ICACHE_REFILL_PERF_EN
    , .perf_refills(perf_refills), .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One refill from accept to the first IDLE cycle after the return pulse.
  // Expected line: accepted beats in order, unfilled words zero; err is OR of accepted rresp.
  task automatic refill(input logic [31:0] addr, input int ar_stall, input int gap_pct,
                        input int err_beat, input int badid_pct, input bit hold,
                        input int nbeats, input bit fixed, output logic [DW-1:0] line);
    logic [31:0]   exp_addr;
    logic [DW-1:0] exp_line;
    logic          exp_err;
    int            b;
    exp_addr = addr & ~(32'(LW * 4) - 32'd1);
    exp_line = '0;
    exp_err  = 1'b0;
    rd_req   = 1'b1;
    rd_addr  = addr;
    chk("rd_rdy_idle", rd_rdy, 1'b1);
    @(negedge clk);
    if (!hold) rd_req = 1'b0;
    rd_addr = $urandom;
    for (int n = 0; n <= ar_stall; n++) begin
      chk("arvalid", arvalid, 1'b1);
      chk("araddr", araddr, exp_addr);
      chk("arlen", arlen, 8'(LW - 1));
      chk("arsize", arsize, 3'b010);
      chk("arburst", arburst, 2'b01);
      chk("arid", arid, AXI_ID);
      chk("ar_side0", {arlock, arcache, arprot, rready, ret_valid, rd_rdy}, '0);
      arready = (n == ar_stall);
      exp_wait++;
      @(negedge clk);
    end
    arready = 1'b0;
    b = 0;
    while (b < nbeats) begin
      chk("rready", {rready, arvalid, ret_valid, rd_rdy}, 4'b1000);
      rdata = $urandom;
      if (int'($urandom_range(99)) < gap_pct) begin
        rvalid = 1'b0;
        rlast  = 1'b1;
      end else if (int'($urandom_range(99)) < badid_pct) begin
        rvalid = 1'b1;
        rid    = AXI_ID ^ 4'd1;
        rresp  = 2'b10;
        rlast  = 1'($urandom);
      end else begin
        rvalid = 1'b1;
        rid    = AXI_ID;
        if (fixed) rdata = 32'hA0 + 32'(b);
        rresp  = (b == err_beat) ? 2'b10 : 2'b00;
        rlast  = (b == nbeats - 1);
        exp_line[b*32 +: 32] = rdata;
        exp_err = exp_err | (rresp != 2'b00);
        b++;
      end
      exp_wait++;
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("ret_valid", ret_valid, 1'b1);
    chk("ret_last", ret_last, 1'b1);
    chk("ret_data", ret_data, exp_line);
    chk("ret_err", ret_err, exp_err);
    chk("rd_rdy_resp", {rd_rdy, arvalid, rready}, 3'b000);
    exp_refills++;
    line = ret_data;
    @(negedge clk);
    chk("ret_pulse", {ret_valid, ret_err, rd_rdy}, 3'b001);
    chk("ret_hold", ret_data, exp_line);
  endtask

  logic [DW-1:0] line;
  logic [31:0]   fixed_line_w;
  logic [DW-1:0] fixed_line;

  initial begin
    fixed_line_w = 32'hA0;
    fixed_line   = '0;
    for (int i = 0; i < LW; i++) fixed_line[i*32 +: 32] = fixed_line_w + 32'(i);

    @(negedge clk);
    chk("rst_outs", {rd_rdy, arvalid, rready, ret_valid, ret_last, ret_err}, 6'b100000);
    chk("rst_data", ret_data, '0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("rst_perf", {perf_refills, perf_wait_cycles}, '0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Aligned-down address, no stalls, fixed data; two more back-to-back refills follow.
    refill(32'h1FC0_0014, 0, 0, -1, 0, 1'b0, LW, 1'b1, line);
    chk("case1_line", line, fixed_line);
    refill($urandom, 0, 0, -1, 0, 1'b0, LW, 1'b0, line);
    refill($urandom, 0, 0, -1, 0, 1'b0, LW, 1'b0, line);
`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_refills3", perf_refills, 32'd3);
    chk("perf_wait15", perf_wait_cycles, 32'd15);
`endif

    refill(32'h8000_123C, 5, 0, -1, 0, 1'b0, LW, 1'b0, line);       // AR stall
    refill(32'h0000_0040, 0, 40, 2, 0, 1'b0, LW, 1'b0, line);       // gaps, beat 2 SLVERR
    refill(32'h0000_0080, 0, 40, -1, 0, 1'b0, LW, 1'b0, line);      // error flag cleared
    refill(32'hDEAD_BEEF, 1, 0, -1, 0, 1'b1, LW, 1'b0, line);       // rd_req held through RESP
    refill(32'h1234_5670, 0, 0, -1, 0, 1'b0, LW, 1'b0, line);
    refill(32'h0000_0100, 0, 20, -1, 30, 1'b0, 2, 1'b0, line);      // early rlast, foreign IDs

    for (int k = 0; k < 25; k++)
      refill($urandom, int'($urandom_range(3)), 30, int'($urandom_range(LW + 1)) - 1, 25,
             1'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(LW - 1, 1)) : LW,
             1'b0, line);
    rd_req = 1'b0;

`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_refills", perf_refills, 32'(exp_refills));
    chk("perf_wait", perf_wait_cycles, 32'(exp_wait));
`endif

    // Reset in the middle of the data phase after two beats.
    rd_req  = 1'b1;
    rd_addr = 32'h0000_2000;
    @(negedge clk);
    rd_req  = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rid = AXI_ID; rdata = $urandom | 32'h1; rresp = 2'b00; rlast = 1'b0;
      @(negedge clk);
    end
    rvalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {rd_rdy, arvalid, rready, ret_valid}, 4'b1000);
    chk("midrst_data", ret_data, '0);
    rst = 1'b0;
    exp_refills = 0;
    exp_wait    = 0;
    @(negedge clk);
    refill(32'h0000_3004, 2, 10, 0, 0, 1'b0, LW, 1'b0, line);
`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_after_rst", {perf_refills, perf_wait_cycles}, {32'(exp_refills), 32'(exp_wait)});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
